// File: rtl/store_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_queue : in-order store buffer with CDB/AGU capture, commit, drain and
//               store-to-load forwarding.   Revision: 1.0
// ----------------------------------------------------------------------------
module store_queue #(
    parameter int  DEPTH   = 8,
    parameter int  ALLOC_W = 2,
    parameter int  CDB_W   = 2,
    parameter int  TAG_W   = 6,
    parameter int  DATA_W  = 32,
    parameter int  ADDR_W  = 32,
    localparam int PTR_W   = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [ALLOC_W-1:0]         alloc_we,
    input  logic [ALLOC_W*TAG_W-1:0]   alloc_tag,
    input  logic [ALLOC_W*TAG_W-1:0]   alloc_data_tag,
    input  logic [ALLOC_W-1:0]         alloc_data_rdy,
    input  logic [ALLOC_W*DATA_W-1:0]  alloc_data,
    input  logic [ALLOC_W*2-1:0]       alloc_size,
    output logic [PTR_W-1:0]           alloc_free,
    output logic [PTR_W-1:0]           alloc_tail,
    input  logic                       agu_valid,
    input  logic [TAG_W-1:0]           agu_tag,
    input  logic [ADDR_W-1:0]          agu_addr,
    input  logic [CDB_W-1:0]           cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]     cdb_tag,
    input  logic [CDB_W*DATA_W-1:0]    cdb_data,
    input  logic                       commit_valid,
    output logic                       mem_req_valid,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_data,
    output logic [1:0]                 mem_req_size,
    input  logic                       mem_req_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [1:0]                 ld_size,
    input  logic [PTR_W-1:0]           ld_stq_tail,
    output logic                       ld_resp_valid,
    output logic                       ld_fwd_hit,
    output logic                       ld_fwd_stall,
    output logic [DATA_W-1:0]          ld_fwd_data,
    output logic                       stq_empty
);
    localparam int IDX_W = PTR_W - 1;

    logic              r_valid     [DEPTH];
    logic [TAG_W-1:0]  r_tag       [DEPTH];
    logic              r_addr_vld  [DEPTH];
    logic [ADDR_W-1:0] r_addr      [DEPTH];
    logic              r_data_vld  [DEPTH];
    logic [TAG_W-1:0]  r_data_tag  [DEPTH];
    logic [DATA_W-1:0] r_data      [DEPTH];
    logic [1:0]        r_size      [DEPTH];
    logic              r_committed [DEPTH];
    logic [PTR_W-1:0]  r_head, r_cmt, r_tail;
    logic              r_ld_valid, r_ld_hit, r_ld_stall;
    logic [DATA_W-1:0] r_ld_data;

    logic [IDX_W-1:0]  w_head_idx, w_cmt_idx;
    logic              w_drain;

    assign w_head_idx    = r_head[IDX_W-1:0];
    assign w_cmt_idx     = r_cmt[IDX_W-1:0];
    assign mem_req_valid = r_valid[w_head_idx] & r_committed[w_head_idx]
                         & r_addr_vld[w_head_idx] & r_data_vld[w_head_idx];
    assign mem_req_addr  = r_addr[w_head_idx];
    assign mem_req_data  = r_data[w_head_idx];
    assign mem_req_size  = r_size[w_head_idx];
    assign w_drain       = mem_req_valid & mem_req_ready;
    assign alloc_free    = PTR_W'(DEPTH) - (r_tail - r_head);
    assign alloc_tail    = r_tail;
    assign stq_empty     = (r_head == r_tail);
    assign ld_resp_valid = r_ld_valid;
    assign ld_fwd_hit    = r_ld_hit;
    assign ld_fwd_stall  = r_ld_stall;
    assign ld_fwd_data   = r_ld_data;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_mask = 4'b0001 << a;
            2'b01:   byte_mask = 4'b0011 << a;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    // Per-entry CDB snoop; descending port loop makes the lowest port win.
    logic              w_cdb_hit  [DEPTH];
    logic [DATA_W-1:0] w_cdb_data [DEPTH];
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_cdb_hit[e]  = 1'b0;
            w_cdb_data[e] = '0;
            for (int p = CDB_W - 1; p >= 0; p--) begin
                if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == r_data_tag[e]) begin
                    w_cdb_hit[e]  = 1'b1;
                    w_cdb_data[e] = cdb_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    logic [IDX_W-1:0]  w_lane_idx  [ALLOC_W];
    logic              w_lane_dvld [ALLOC_W];
    logic [DATA_W-1:0] w_lane_data [ALLOC_W];
    logic [PTR_W-1:0]  w_alloc_cnt;
    always_comb begin
        w_alloc_cnt = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            w_lane_idx[i]  = w_tail_idx_base() + IDX_W'(i);
            w_lane_dvld[i] = alloc_data_rdy[i];
            w_lane_data[i] = alloc_data[i*DATA_W +: DATA_W];
            for (int p = CDB_W - 1; p >= 0; p--) begin
                if (!alloc_data_rdy[i] && cdb_valid[p]
                    && cdb_tag[p*TAG_W +: TAG_W] == alloc_data_tag[i*TAG_W +: TAG_W]) begin
                    w_lane_dvld[i] = 1'b1;
                    w_lane_data[i] = cdb_data[p*DATA_W +: DATA_W];
                end
            end
            w_alloc_cnt = w_alloc_cnt + PTR_W'(alloc_we[i]);
        end
    end

    function automatic logic [IDX_W-1:0] w_tail_idx_base();
        return r_tail[IDX_W-1:0];
    endfunction

    // Forwarding scan runs oldest to youngest so the youngest overlap is left standing.
    logic [3:0]        w_ld_mask, w_st_mask;
    logic [PTR_W-1:0]  w_range;
    logic [IDX_W-1:0]  w_scan_idx;
    logic              w_noaddr, w_found, w_cover, w_fdvld;
    logic [DATA_W-1:0] w_fdata, w_shift, w_fwd;
    logic [1:0]        w_fsa;
    always_comb begin
        w_ld_mask  = byte_mask(ld_size, ld_addr[1:0]);
        w_range    = ld_stq_tail - r_head;
        w_noaddr   = 1'b0;
        w_found    = 1'b0;
        w_cover    = 1'b0;
        w_fdvld    = 1'b0;
        w_fdata    = '0;
        w_fsa      = '0;
        w_scan_idx = '0;
        w_st_mask  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = w_head_idx + IDX_W'(k);
            w_st_mask  = byte_mask(r_size[w_scan_idx], r_addr[w_scan_idx][1:0]);
            if (PTR_W'(k) < w_range && r_valid[w_scan_idx]) begin
                if (!r_addr_vld[w_scan_idx]) begin
                    w_noaddr = 1'b1;
                end else if (r_addr[w_scan_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]
                             && (w_st_mask & w_ld_mask) != 4'b0000) begin
                    w_found = 1'b1;
                    w_cover = ((w_st_mask & w_ld_mask) == w_ld_mask);
                    w_fdvld = r_data_vld[w_scan_idx];
                    w_fdata = r_data[w_scan_idx];
                    w_fsa   = r_addr[w_scan_idx][1:0];
                end
            end
        end
        w_shift = (w_fdata << {w_fsa, 3'b000}) >> {ld_addr[1:0], 3'b000};
        case (ld_size)
            2'b00:   w_fwd = {{(DATA_W-8){1'b0}},  w_shift[7:0]};
            2'b01:   w_fwd = {{(DATA_W-16){1'b0}}, w_shift[15:0]};
            default: w_fwd = w_shift;
        endcase
    end

    logic w_hit, w_stall;
    assign w_hit   = w_found & w_cover & w_fdvld & ~w_noaddr;
    assign w_stall = w_noaddr | (w_found & ~(w_cover & w_fdvld));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_valid[e]     <= 1'b0;
                r_tag[e]       <= '0;
                r_addr_vld[e]  <= 1'b0;
                r_addr[e]      <= '0;
                r_data_vld[e]  <= 1'b0;
                r_data_tag[e]  <= '0;
                r_data[e]      <= '0;
                r_size[e]      <= '0;
                r_committed[e] <= 1'b0;
            end
            r_head     <= '0;
            r_cmt      <= '0;
            r_tail     <= '0;
            r_ld_valid <= 1'b0;
            r_ld_hit   <= 1'b0;
            r_ld_stall <= 1'b0;
            r_ld_data  <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (r_valid[e] && !r_data_vld[e] && w_cdb_hit[e]) begin
                    r_data_vld[e] <= 1'b1;
                    r_data[e]     <= w_cdb_data[e];
                end
                if (r_valid[e] && agu_valid && r_tag[e] == agu_tag) begin
                    r_addr_vld[e] <= 1'b1;
                    r_addr[e]     <= agu_addr;
                end
                // The entry committed in this same cycle survives the flush.
                if (flush && r_valid[e] && !r_committed[e]
                    && !(commit_valid && IDX_W'(e) == w_cmt_idx)) begin
                    r_valid[e] <= 1'b0;
                end
            end
            if (commit_valid) begin
                r_committed[w_cmt_idx] <= 1'b1;
                r_cmt                  <= r_cmt + PTR_W'(1);
            end
            if (w_drain) begin
                r_valid[w_head_idx]     <= 1'b0;
                r_committed[w_head_idx] <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            if (flush) begin
                r_tail <= commit_valid ? r_cmt + PTR_W'(1) : r_cmt;
            end else begin
                for (int i = 0; i < ALLOC_W; i++) begin
                    if (alloc_we[i]) begin
                        r_valid[w_lane_idx[i]]     <= 1'b1;
                        r_tag[w_lane_idx[i]]       <= alloc_tag[i*TAG_W +: TAG_W];
                        r_addr_vld[w_lane_idx[i]]  <= 1'b0;
                        r_data_vld[w_lane_idx[i]]  <= w_lane_dvld[i];
                        r_data_tag[w_lane_idx[i]]  <= alloc_data_tag[i*TAG_W +: TAG_W];
                        r_data[w_lane_idx[i]]      <= w_lane_data[i];
                        r_size[w_lane_idx[i]]      <= alloc_size[i*2 +: 2];
                        r_committed[w_lane_idx[i]] <= 1'b0;
                    end
                end
                r_tail <= r_tail + w_alloc_cnt;
            end
            r_ld_valid <= ld_valid;
            r_ld_hit   <= ld_valid & w_hit;
            r_ld_stall <= ld_valid & w_stall;
            r_ld_data  <= (ld_valid && w_hit) ? w_fwd : '0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// tb_store_queue : directed stimulus with a scoreboard for drained stores and
//                  forwarding responses, checked by a decoupled monitor.
module tb_store_queue;
    localparam int DEPTH = 8, ALLOC_W = 2, CDB_W = 2, TAG_W = 6, DATA_W = 32, ADDR_W = 32;
    localparam int PTR_W = 4;

    logic clk = 1'b0;
    logic rst, flush;
    logic [ALLOC_W-1:0]        alloc_we;
    logic [ALLOC_W*TAG_W-1:0]  alloc_tag, alloc_data_tag;
    logic [ALLOC_W-1:0]        alloc_data_rdy;
    logic [ALLOC_W*DATA_W-1:0] alloc_data;
    logic [ALLOC_W*2-1:0]      alloc_size;
    logic [PTR_W-1:0]          alloc_free, alloc_tail;
    logic                      agu_valid;
    logic [TAG_W-1:0]          agu_tag;
    logic [ADDR_W-1:0]         agu_addr;
    logic [CDB_W-1:0]          cdb_valid;
    logic [CDB_W*TAG_W-1:0]    cdb_tag;
    logic [CDB_W*DATA_W-1:0]   cdb_data;
    logic                      commit_valid;
    logic                      mem_req_valid, mem_req_ready;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [DATA_W-1:0]         mem_req_data;
    logic [1:0]                mem_req_size;
    logic                      ld_valid;
    logic [ADDR_W-1:0]         ld_addr;
    logic [1:0]                ld_size;
    logic [PTR_W-1:0]          ld_stq_tail;
    logic                      ld_resp_valid, ld_fwd_hit, ld_fwd_stall;
    logic [DATA_W-1:0]         ld_fwd_data;
    logic                      stq_empty;

    store_queue #(.DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .CDB_W(CDB_W), .TAG_W(TAG_W),
                  .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_we(alloc_we), .alloc_tag(alloc_tag), .alloc_data_tag(alloc_data_tag),
        .alloc_data_rdy(alloc_data_rdy), .alloc_data(alloc_data), .alloc_size(alloc_size),
        .alloc_free(alloc_free), .alloc_tail(alloc_tail),
        .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_size(mem_req_size), .mem_req_ready(mem_req_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_stq_tail(ld_stq_tail),
        .ld_resp_valid(ld_resp_valid), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_stall(ld_fwd_stall),
        .ld_fwd_data(ld_fwd_data), .stq_empty(stq_empty)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] size; } mem_t;
    typedef struct { logic hit; logic stall; logic [31:0] data; } ld_t;
    mem_t mem_q[$];
    ld_t  ld_q[$];
    mem_t me;
    ld_t  le;
    int   checks = 0;
    int   failures = 0;
    int   ncom;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; alloc_we = '0; agu_valid = 1'b0; cdb_valid = '0;
        commit_valid = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int ln, input logic [5:0] tag, input logic [5:0] dtag,
                            input logic rdy, input logic [31:0] data, input logic [1:0] size);
        alloc_we[ln]                    = 1'b1;
        alloc_tag[ln*TAG_W +: TAG_W]      = tag;
        alloc_data_tag[ln*TAG_W +: TAG_W] = dtag;
        alloc_data_rdy[ln]              = rdy;
        alloc_data[ln*DATA_W +: DATA_W]   = data;
        alloc_size[ln*2 +: 2]            = size;
    endtask

    task automatic alloc_one(input logic [5:0] tag, input logic [31:0] data, input logic [1:0] size);
        set_lane(0, tag, 6'd0, 1'b1, data, size);
        tick(); idle();
    endtask

    task automatic agu(input logic [5:0] tag, input logic [31:0] addr);
        agu_valid = 1'b1; agu_tag = tag; agu_addr = addr;
        tick(); idle();
    endtask

    task automatic commit_n(input int n);
        for (int i = 0; i < n; i++) begin
            commit_valid = 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic expect_mem(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        mem_t e;
        e.addr = a; e.data = d; e.size = s;
        mem_q.push_back(e);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] tl,
                        input logic hit, input logic stall, input logic [31:0] d);
        ld_t e;
        e.hit = hit; e.stall = stall; e.data = d;
        ld_q.push_back(e);
        ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_stq_tail = tl;
        tick(); idle();
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int c = 0; c < budget && !stq_empty; c++) tick();
        chk(name, stq_empty, 1'b1);
    endtask

    initial begin
        rst = 1'b1; mem_req_ready = 1'b0;
        alloc_tag = '0; alloc_data_tag = '0; alloc_data_rdy = '0; alloc_data = '0; alloc_size = '0;
        agu_tag = '0; agu_addr = '0; cdb_tag = '0; cdb_data = '0;
        ld_addr = '0; ld_size = '0; ld_stq_tail = '0;
        idle();

        fork
            forever begin
                @(negedge clk);
                if (!rst && mem_req_valid && mem_req_ready) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected_req", mem_req_addr, 32'hFFFF_FFFF);
                    end else begin
                        me = mem_q.pop_front();
                        chk("mem_addr", mem_req_addr, me.addr);
                        chk("mem_data", mem_req_data, me.data);
                        chk("mem_size", {30'd0, mem_req_size}, {30'd0, me.size});
                    end
                end
                if (!rst && ld_resp_valid) begin
                    if (ld_q.size() == 0) begin
                        chk("ld_unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        le = ld_q.pop_front();
                        chk("ld_hit", ld_fwd_hit, le.hit);
                        chk("ld_stall", ld_fwd_stall, le.stall);
                        chk("ld_data", ld_fwd_data, le.data);
                    end
                end
            end
        join_none

        // Reset, with an alloc held during reset that must be ignored
        repeat (2) tick();
        set_lane(0, 6'd1, 6'd0, 1'b1, 32'h1, 2'b10);
        tick(); tick(); idle();
        chk("rst_free", alloc_free, 8);
        chk("rst_tail", alloc_tail, 0);
        chk("rst_empty", stq_empty, 1);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_ld_resp", ld_resp_valid, 0);
        chk("rst_ld_hit", ld_fwd_hit, 0);
        chk("rst_ld_stall", ld_fwd_stall, 0);
        chk("rst_ld_data", ld_fwd_data, 0);
        rst = 1'b0;
        tick();

        // Single store
        mem_req_ready = 1'b1;
        alloc_one(6'd8, 32'h0F, 2'b10);
        chk("single_free", alloc_free, 7);
        chk("single_tail", alloc_tail, 1);
        chk("single_not_empty", stq_empty, 0);
        agu(6'd8, 32'h100);
        expect_mem(32'h100, 32'h0F, 2'b10);
        commit_n(1);
        wait_empty("single_drain_empty", 20);
        chk("single_free_after", alloc_free, 8);

        // Forward hit
        alloc_one(6'd10, 32'hAABBCCDD, 2'b10);
        agu(6'd10, 32'h200);
        load(32'h202, 2'b00, 4'd2, 1'b1, 1'b0, 32'h000000BB);
        load(32'h200, 2'b10, 4'd1, 1'b0, 1'b0, 32'h0);
        load(32'h200, 2'b01, 4'd2, 1'b1, 1'b0, 32'h0000CCDD);
        expect_mem(32'h200, 32'hAABBCCDD, 2'b10);
        commit_n(1);
        wait_empty("fwd_drain_empty", 20);

        // Partial overlap, no overlap, missing older address
        alloc_one(6'd11, 32'h55, 2'b00);
        agu(6'd11, 32'h300);
        load(32'h300, 2'b10, 4'd3, 1'b0, 1'b1, 32'h0);
        load(32'h300, 2'b00, 4'd3, 1'b1, 1'b0, 32'h55);
        load(32'h302, 2'b01, 4'd3, 1'b0, 1'b0, 32'h0);
        alloc_one(6'd12, 32'h77, 2'b10);
        load(32'h300, 2'b00, 4'd4, 1'b0, 1'b1, 32'h0);
        agu(6'd12, 32'h400);
        load(32'h400, 2'b00, 4'd4, 1'b1, 1'b0, 32'h77);
        expect_mem(32'h300, 32'h55, 2'b00);
        expect_mem(32'h400, 32'h77, 2'b10);
        commit_n(2);
        wait_empty("stall_drain_empty", 20);

        // CDB bypass at allocation (two ports match, lowest wins), then a late capture
        set_lane(0, 6'd13, 6'd5, 1'b0, 32'hDEAD0000, 2'b10);
        cdb_valid = 2'b11; cdb_tag = {6'd5, 6'd5}; cdb_data = {32'h9999, 32'h1234};
        tick(); idle();
        agu(6'd13, 32'h500);
        expect_mem(32'h500, 32'h1234, 2'b10);
        set_lane(0, 6'd14, 6'd6, 1'b0, 32'h0, 2'b10);
        tick(); idle();
        agu(6'd14, 32'h600);
        load(32'h600, 2'b10, 4'd6, 1'b0, 1'b1, 32'h0);
        cdb_valid = 2'b10; cdb_tag = {6'd6, 6'd0}; cdb_data = {32'hBEEF, 32'h0};
        tick(); idle();
        load(32'h600, 2'b10, 4'd6, 1'b1, 1'b0, 32'hBEEF);
        expect_mem(32'h600, 32'hBEEF, 2'b10);
        commit_n(2);
        wait_empty("cdb_drain_empty", 20);

        // Fill to DEPTH with 2-lane bursts, head at pointer 6 so the range wraps
        for (int b = 0; b < 4; b++) begin
            set_lane(0, 6'(20 + 2*b), 6'd0, 1'b1, 32'h1000 + 2*b, 2'b10);
            set_lane(1, 6'(21 + 2*b), 6'd0, 1'b1, 32'h1000 + 2*b + 1, 2'b10);
            tick(); idle();
        end
        chk("fill_free", alloc_free, 0);
        chk("fill_tail", alloc_tail, 14);
        for (int k = 0; k < 8; k++) begin
            agu(6'(20 + k), 32'h1000 + 4*k);
            expect_mem(32'h1000 + 4*k, 32'h1000 + k, 2'b10);
        end
        load(32'h101C, 2'b10, 4'd14, 1'b1, 1'b0, 32'h1007);
        load(32'h101C, 2'b00, 4'd14, 1'b1, 1'b0, 32'h07);
        load(32'h1004, 2'b10, 4'd14, 1'b1, 1'b0, 32'h1001);
        ncom = 0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 60 && !(ncom == 8 && stq_empty); c++) begin
            commit_valid = (ncom < 8);
            if (ncom < 8) ncom++;
            tick();
            commit_valid = 1'b0;
            mem_req_ready = ~mem_req_ready;
        end
        chk("fill_drain_empty", stq_empty, 1);
        mem_req_ready = 1'b1;

        // Refill across the pointer wrap
        set_lane(0, 6'd40, 6'd0, 1'b1, 32'hA0, 2'b10);
        set_lane(1, 6'd41, 6'd0, 1'b1, 32'hA1, 2'b10);
        tick(); idle();
        chk("wrap_tail", alloc_tail, 0);
        chk("wrap_free", alloc_free, 6);
        agu(6'd40, 32'h2000);
        agu(6'd41, 32'h2004);
        load(32'h2004, 2'b10, 4'd0, 1'b1, 1'b0, 32'hA1);
        expect_mem(32'h2000, 32'hA0, 2'b10);
        expect_mem(32'h2004, 32'hA1, 2'b10);
        commit_n(2);
        wait_empty("wrap_drain_empty", 20);

        // Flush: 3 committed, 3 uncommitted, cache stalled
        mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            set_lane(0, 6'(30 + 2*b), 6'd0, 1'b1, 32'h300 + 2*b, 2'b10);
            set_lane(1, 6'(31 + 2*b), 6'd0, 1'b1, 32'h300 + 2*b + 1, 2'b10);
            tick(); idle();
        end
        for (int k = 0; k < 6; k++) agu(6'(30 + k), 32'h3000 + 4*k);
        commit_n(3);
        chk("stall_valid", mem_req_valid, 1);
        chk("stall_addr", mem_req_addr, 32'h3000);
        flush = 1'b1;
        tick(); idle();
        chk("flush_free", alloc_free, 5);
        chk("flush_tail", alloc_tail, 3);
        chk("flush_hold_addr", mem_req_addr, 32'h3000);
        for (int k = 0; k < 3; k++) expect_mem(32'h3000 + 4*k, 32'h300 + k, 2'b10);
        mem_req_ready = 1'b1;
        wait_empty("flush_drain_empty", 20);
        chk("flush_free_after", alloc_free, 8);

        // Commit and flush together, with an alloc that must be dropped
        set_lane(0, 6'd50, 6'd0, 1'b1, 32'h50, 2'b10);
        set_lane(1, 6'd51, 6'd0, 1'b1, 32'h51, 2'b10);
        tick(); idle();
        agu(6'd50, 32'h5000);
        agu(6'd51, 32'h5004);
        expect_mem(32'h5000, 32'h50, 2'b10);
        set_lane(0, 6'd52, 6'd0, 1'b1, 32'h52, 2'b10);
        commit_valid = 1'b1; flush = 1'b1;
        tick(); idle();
        chk("cf_tail", alloc_tail, 4);
        chk("cf_free", alloc_free, 7);
        wait_empty("cf_drain_empty", 20);

        repeat (4) tick();
        chk("mem_q_left", mem_q.size(), 0);
        chk("ld_q_left", ld_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
